add_fu: RTL



---
 rtl/tomasulo_pkg.sv | 32 +++
 rtl/add_fu_if.sv | 43 ++++
 rtl/add_alu.sv | 57 +++++
 rtl/add_fu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo execution slice: datapath widths, the
// "no producer" tag value, ALU operation encodings and the add_fu FSM states.
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    // Tag value meaning "no producer"; never a legal issuing station.
    localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } op_e;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_BCAST = 2'd2
    } fu_state_e;

endpackage

// File: rtl/add_fu_if.sv
// -----------------------------------------------------------------------------
// add_fu_if
// Bundles the issue-side signals (start/op/vj/vk/rs_tag) and the CDB
// broadcast signals (cdb_grant/cdb_req/cdb_tag/cdb_data/done/fu_busy).
//   master : reservation station + CDB arbiter side (drives issue and grant)
//   slave  : the adder functional unit
// Optional macro ADD_FU_OVF_EN adds cdb_ovf (signed overflow flag).
// -----------------------------------------------------------------------------
interface add_fu_if;
    import tomasulo_pkg::*;

    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  rs_tag;
    logic              cdb_grant;
    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              fu_busy;
    logic              done;
`ifdef ADD_FU_OVF_EN
    logic              cdb_ovf;
`endif

    modport master (
        output start, op, vj, vk, rs_tag, cdb_grant,
`ifdef ADD_FU_OVF_EN
        input  cdb_ovf,
`endif
        input  cdb_req, cdb_tag, cdb_data, fu_busy, done
    );

    modport slave (
        input  start, op, vj, vk, rs_tag, cdb_grant,
`ifdef ADD_FU_OVF_EN
        output cdb_ovf,
`endif
        output cdb_req, cdb_tag, cdb_data, fu_busy, done
    );

endinterface

// File: rtl/add_alu.sv
// -----------------------------------------------------------------------------
// add_alu
// Purely combinational ALU for the adder functional unit.
//   op     in  3       operation code (tomasulo_pkg::op_e)
//   vj     in  DATA_W  operand j
//   vk     in  DATA_W  operand k (shift amount taken from vk[4:0])
//   result out DATA_W  two's-complement result, truncated
//   ovf    out 1       signed overflow of ADD/SUB (only with ADD_FU_OVF_EN)
// -----------------------------------------------------------------------------
module add_alu
    import tomasulo_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
`ifdef ADD_FU_OVF_EN
    output logic              ovf,
`endif
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;

    assign sum_s  = vj + vk;
    assign diff_s = vj - vk;

    // Operation select.
    always_comb begin
        result = {DATA_W{1'b0}};
        case (op)
            OP_ADD:  result = sum_s;
            OP_SUB:  result = diff_s;
            OP_AND:  result = vj & vk;
            OP_OR:   result = vj | vk;
            OP_XOR:  result = vj ^ vk;
            OP_SLL:  result = vj << vk[4:0];
            OP_SRL:  result = vj >> vk[4:0];
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(vj) < $signed(vk))};
            default: result = {DATA_W{1'b0}};
        endcase
    end

`ifdef ADD_FU_OVF_EN
    // Signed overflow: ADD when operands agree in sign and the sum does not;
    // SUB when operands differ in sign and the difference leaves vj's sign.
    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD:  ovf = (vj[DATA_W-1] == vk[DATA_W-1]) && (sum_s[DATA_W-1]  != vj[DATA_W-1]);
            OP_SUB:  ovf = (vj[DATA_W-1] != vk[DATA_W-1]) && (diff_s[DATA_W-1] != vj[DATA_W-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/add_fu.sv
// -----------------------------------------------------------------------------
// add_fu
// Adder functional unit behind the add reservation station. On a rising edge
// of start (with a non-zero rs_tag, while idle) it latches op/vj/vk/rs_tag,
// waits LAT cycles, then requests the CDB and holds tag+result until granted.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    add_fu_if.slave: start, op, vj, vk, rs_tag, cdb_grant in;
//          cdb_req, cdb_tag, cdb_data, fu_busy, done (and cdb_ovf) out
// Parameter LAT: execute latency in cycles, 1..15.
// Optional macro ADD_FU_OVF_EN adds the registered cdb_ovf output.
// -----------------------------------------------------------------------------
module add_fu
    import tomasulo_pkg::*;
#(
    parameter int LAT = 3
)(
    input  logic     clk,
    input  logic     rst_n,
    add_fu_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    fu_state_e         state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              start_prev_q;
    logic [2:0]        op_q,       op_d;
    logic [DATA_W-1:0] vj_q,       vj_d;
    logic [DATA_W-1:0] vk_q,       vk_d;
    logic [TAG_W-1:0]  tag_q,      tag_d;
    logic              cdb_req_q,  cdb_req_d;
    logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              done_q,     done_d;
    logic              ovf_q,      ovf_d;
    logic              alu_ovf_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              accept_s;

    add_alu u_alu (
        .op     (op_q),
        .vj     (vj_q),
        .vk     (vk_q),
`ifdef ADD_FU_OVF_EN
        .ovf    (alu_ovf_s),
`endif
        .result (alu_result_s)
    );

`ifndef ADD_FU_OVF_EN
    assign alu_ovf_s = 1'b0;
`endif

    // Only a fresh rising edge of start from a real producer starts work.
    assign accept_s = bus.start & ~start_prev_q & (bus.rs_tag != TAG_NONE)
                      & (state_q == ST_IDLE);

    // Next-state, operand latch and CDB register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        tag_d      = tag_q;
        cdb_req_d  = cdb_req_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d    = bus.op;
                    vj_d    = bus.vj;
                    vk_d    = bus.vk;
                    tag_d   = bus.rs_tag;
                    cnt_d   = CNT_INIT;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    cdb_data_d = alu_result_s;
                    cdb_tag_d  = tag_q;
                    ovf_d      = alu_ovf_s;
                    cdb_req_d  = 1'b1;
                    state_d    = ST_BCAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_BCAST: begin
                // Tag/data stay put after the grant; only req drops.
                if (bus.cdb_grant) begin
                    cdb_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cdb_req_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = 4'd0;
                cdb_req_d  = 1'b0;
                cdb_tag_d  = TAG_NONE;
                cdb_data_d = {DATA_W{1'b0}};
                ovf_d      = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // State, counter, operand and CDB registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            start_prev_q <= 1'b0;
            op_q         <= 3'd0;
            vj_q         <= {DATA_W{1'b0}};
            vk_q         <= {DATA_W{1'b0}};
            tag_q        <= TAG_NONE;
            cdb_req_q    <= 1'b0;
            cdb_tag_q    <= TAG_NONE;
            cdb_data_q   <= {DATA_W{1'b0}};
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= bus.start;
            op_q         <= op_d;
            vj_q         <= vj_d;
            vk_q         <= vk_d;
            tag_q        <= tag_d;
            cdb_req_q    <= cdb_req_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.cdb_req  = cdb_req_q;
    assign bus.cdb_tag  = cdb_tag_q;
    assign bus.cdb_data = cdb_data_q;
    assign bus.done     = done_q;
    assign bus.fu_busy  = (state_q != ST_IDLE);
`ifdef ADD_FU_OVF_EN
    assign bus.cdb_ovf  = ovf_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_q ^ alu_ovf_s;
`endif

endmodule
